product_accumulator: RTL and testbench



---
 rtl/product_accumulator.sv | 146 ++++++++++++++
 tb/tb_product_accumulator.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sits directly after the 4x4 combinational multiplier. It accepts the 8-bit
// product stream over a valid/ready handshake and adds FRAME_LEN products per
// frame into a saturating ACC_W-bit accumulator. It then sends the frame sum
// downstream as a little-endian byte pair, with sum_last flagging the upper
// byte.
//
// Handshake rule for both interfaces: a transfer happens on a rising clk edge
// where valid and ready are both high. After a producer raises valid, it keeps
// valid and its data stable until that transfer. The ready signal never
// depends on valid.
//
// Parameters:
//   ACC_W      accumulator width, 9..16 (sum always sent as two bytes)
//   FRAME_LEN  products per frame, 1..255
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   ena                 gates product acceptance only
//   clear               sync abort/flush, overrides every other event
//   prod_in/_valid/_ready  product input handshake
//   sum_out/_valid/_ready  byte output handshake
//   sum_last            high on the upper (final) byte of a frame
//   overflow            sticky saturation flag for the current frame
//   state_dbg           current FSM state (0 ACCUM, 1 SEND_LO, 2 SEND_HI)
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clear,
  input  logic [7:0] prod_in,
  input  logic       prod_valid,
  output logic       prod_ready,
  output logic [7:0] sum_out,
  output logic       sum_valid,
  input  logic       sum_ready,
  output logic       sum_last,
  output logic       overflow,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       count;
  logic             ovf;

  logic             accept;
  logic [ACC_W:0]   sum_wide;
  logic [15:0]      acc_ext;

  // The input side opens only while accumulating. It is forced shut during
  // reset so upstream never sees a false ready.
  assign prod_ready = rst_n & ena & (state == ACCUM);
  assign accept     = prod_valid & prod_ready;

  // One extra bit holds the carry-out. That carry is the saturation
  // indicator.
  assign sum_wide = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod_in};

  // Zero-extend to 16 bits so the upper byte slice works for any legal ACC_W.
  assign acc_ext = 16'(acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      // Flush wins over everything. A product offered in this cycle is
      // dropped.
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (sum_wide[ACC_W]) begin
              acc <= '1;
              ovf <= 1'b1;
            end else begin
              acc <= sum_wide[ACC_W-1:0];
            end
            if (count == LAST_IDX) begin
              count <= '0;
              state <= SEND_LO;
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        SEND_LO: begin
          if (sum_ready) state <= SEND_HI;
        end
        SEND_HI: begin
          if (sum_ready) begin
            state <= ACCUM;
            acc   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // All outputs are decoded from registered state only. The byte on the bus
  // therefore cannot move while it waits for sum_ready.
  always_comb begin
    sum_out   = 8'h00;
    sum_valid = 1'b0;
    sum_last  = 1'b0;
    case (state)
      SEND_LO: begin
        sum_out   = acc_ext[7:0];
        sum_valid = 1'b1;
      end
      SEND_HI: begin
        sum_out   = acc_ext[15:8];
        sum_valid = 1'b1;
        sum_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign overflow  = ovf;
  assign state_dbg = state;

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// Bench for product_accumulator. There are two instances. Instance a uses
// FRAME_LEN=4 for the general scenarios. Instance b uses FRAME_LEN=32 for the
// saturation scenario. The inputs are shared, prod_valid is steered by sel,
// and the outputs are muxed by sel.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int W = 10;  // {overflow, last, byte}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT wiring ----------------
  logic       ena = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] prod_in = 8'h00;
  logic       prod_valid = 1'b0;
  logic       sum_ready = 1'b1;
  logic       sel = 1'b0;

  logic       pr_a, sv_a, sl_a, ov_a, pr_b, sv_b, sl_b, ov_b;
  logic [7:0] so_a, so_b;
  logic [1:0] st_a, st_b;

  product_accumulator #(.ACC_W(12), .FRAME_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
    .prod_in(prod_in), .prod_valid(prod_valid & ~sel), .prod_ready(pr_a),
    .sum_out(so_a), .sum_valid(sv_a), .sum_ready(sum_ready),
    .sum_last(sl_a), .overflow(ov_a), .state_dbg(st_a)
  );

  product_accumulator #(.ACC_W(12), .FRAME_LEN(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
    .prod_in(prod_in), .prod_valid(prod_valid & sel), .prod_ready(pr_b),
    .sum_out(so_b), .sum_valid(sv_b), .sum_ready(sum_ready),
    .sum_last(sl_b), .overflow(ov_b), .state_dbg(st_b)
  );

  wire       prod_ready = sel ? pr_b : pr_a;
  wire [7:0] sum_out    = sel ? so_b : so_a;
  wire       sum_valid  = sel ? sv_b : sv_a;
  wire       sum_last   = sel ? sl_b : sl_a;
  wire       overflow   = sel ? ov_b : ov_a;
  wire [1:0] state_dbg  = sel ? st_b : st_a;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           m_sum = 0;
  int           m_cnt = 0;
  logic         m_ovf = 1'b0;

  function automatic int frame_len();
    return sel ? 32 : 4;
  endfunction

  task automatic model_reset();
    m_sum = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] v);
    m_sum = m_sum + int'(v);
    if (m_sum > 4095) begin
      m_sum = 4095;
      m_ovf = 1'b1;
    end
    m_cnt++;
    if (m_cnt == frame_len()) begin
      exp_q.push_back({m_ovf, 1'b0, 8'(m_sum & 255)});
      exp_q.push_back({m_ovf, 1'b1, 8'((m_sum >> 8) & 255)});
      model_reset();
    end
  endtask

  // Output monitor: a byte transfers on the next rising edge if valid&ready.
  always @(negedge clk) begin
    if (rst_n && sum_valid && sum_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 16'(sum_out), 16'hFFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sum_byte", 16'(sum_out), 16'(e[7:0]));
        check("sum_last", 16'(sum_last), 16'(e[8]));
        check("overflow_send", 16'(overflow), 16'(e[9]));
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic put(input logic [7:0] v);
    int t;
    prod_in    = v;
    prod_valid = 1'b1;
    t = 0;
    while (!prod_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) check("accept_timeout", 16'(t), 16'd0);
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    model_accept(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 16'(exp_q.size()), 16'd0);
    check("idle_after_send", 16'(sum_valid), 16'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    ena = 1'b1;
    #12;
    // Reset values while rst_n is low.
    check("rst_prod_ready", 16'(prod_ready), 16'd0);
    check("rst_sum_valid", 16'(sum_valid), 16'd0);
    check("rst_sum_out", 16'(sum_out), 16'd0);
    check("rst_sum_last", 16'(sum_last), 16'd0);
    check("rst_overflow", 16'(overflow), 16'd0);
    check("rst_state", 16'(state_dbg), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 16'(prod_ready), 16'd1);

    // 1: basic frame with latency check.
    sum_ready = 1'b1;
    put(8'd225); put(8'd3); put(8'd0);
    check("t1_not_valid_early", 16'(sum_valid), 16'd0);
    put(8'd12);
    check("t1_valid_latency", 16'(sum_valid), 16'd1);
    check("t1_prod_ready_low", 16'(prod_ready), 16'd0);
    drain();

    // 2: backpressure in SEND_LO, with an ignored prod_valid pulse.
    sum_ready = 1'b0;
    put(8'd225); put(8'd3); put(8'd0); put(8'd12);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        prod_in = 8'd99;
        prod_valid = 1'b1;
      end else begin
        prod_valid = 1'b0;
      end
      @(negedge clk);
      check("t2_hold_byte", 16'(sum_out), 16'h00F0);
      check("t2_hold_valid", 16'(sum_valid), 16'd1);
      check("t2_prod_ready", 16'(prod_ready), 16'd0);
      @(posedge clk);
      #1;
    end
    prod_valid = 1'b0;
    sum_ready = 1'b1;
    drain();

    // 3: saturation on the FRAME_LEN=32 instance.
    sel = 1'b1;
    #1;
    for (int i = 1; i <= 32; i++) begin
      put(8'd225);
      if (i == 18) check("t3_ovf_before", 16'(overflow), 16'd0);
      if (i == 19) check("t3_ovf_at_19", 16'(overflow), 16'd1);
    end
    drain();
    check("t3_ovf_cleared", 16'(overflow), 16'd0);
    sel = 1'b0;
    #1;

    // 4: idle gaps and ena low mid-frame.
    put(8'd10);
    idle(2);
    put(8'd10);
    ena = 1'b0;
    prod_in = 8'd10;
    prod_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_ready_tracks_ena", 16'(prod_ready), 16'd0);
      @(posedge clk);
      #1;
    end
    prod_valid = 1'b0;
    ena = 1'b1;
    #1;
    check("t4_ready_back", 16'(prod_ready), 16'd1);
    put(8'd10);
    idle(1);
    put(8'd10);
    drain();

    // 5: clear mid-frame drops the product offered with it.
    put(8'd100); put(8'd100);
    prod_in = 8'd50;
    prod_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    prod_valid = 1'b0;
    model_reset();
    check("t5_no_send", 16'(sum_valid), 16'd0);
    put(8'd1); put(8'd1); put(8'd1); put(8'd1);
    drain();

    // 6: async reset while in SEND_HI.
    sum_ready = 1'b0;
    put(8'd200); put(8'd200); put(8'd200); put(8'd200);
    sum_ready = 1'b1;
    @(posedge clk);
    #1;
    sum_ready = 1'b0;
    check("t6_in_send_hi", 16'(sum_last), 16'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check("t6_rst_valid", 16'(sum_valid), 16'd0);
    check("t6_rst_last", 16'(sum_last), 16'd0);
    check("t6_rst_out", 16'(sum_out), 16'd0);
    check("t6_rst_ovf", 16'(overflow), 16'd0);
    check("t6_rst_ready", 16'(prod_ready), 16'd0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sum_ready = 1'b1;
    put(8'd7); put(8'd7); put(8'd7); put(8'd7);
    drain();

    // Random frames as a final sweep, with a randomly stalled output.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) begin
        sum_ready = 1'($urandom_range(0, 1));
        put(8'($urandom_range(0, 255)));
        idle($urandom_range(0, 2));
      end
      sum_ready = 1'b1;
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
